// File: rtl/interleaver_pp_sched.sv
// Ping-pong interleaver scheduler: writes coded bits into bank A/B at the
// 802.16 QPSK interleaved address, then streams the full bank out linearly
// with valid/ready backpressure. Owns all enables/addresses of both banks.
module interleaver_pp_sched #(
  parameter int BLOCK_BITS = 192,
  parameter int D          = 16,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              wren_A,
  output logic              wren_B,
  output logic [ADDR_W-1:0] wraddress_A,
  output logic [ADDR_W-1:0] wraddress_B,
  output logic              wrdata_A,
  output logic              wrdata_B,
  output logic              rden_A,
  output logic              rden_B,
  output logic [ADDR_W-1:0] rdaddress_A,
  output logic [ADDR_W-1:0] rdaddress_B,
  input  logic              q_A,
  input  logic              q_B,
  output logic [1:0]        bank_full
);

  localparam int ROWS  = BLOCK_BITS / D;
  localparam int COL_W = $clog2(D);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BLOCK_BITS - 1);
  // mk advances by one row stride; at the end of a column it jumps back to
  // the top of the next column (180 -> 1 for the 192/16 geometry).
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ROWS);
  localparam logic [ADDR_W-1:0] WRAP = ADDR_W'(BLOCK_BITS - ROWS - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        full_q, full_d;
  logic              rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              valid_out_q, valid_out_d;
  logic              rd_src_q, rd_src_d;

  logic wr_acc, rd_issue;

  assign ready_out = ~full_q[wr_sel_q];
  assign wr_acc    = valid_in & ready_out;
  // A bank is read only once complete, and the output register must be free
  assign rd_issue  = full_q[rd_sel_q] & (~valid_out_q | ready_in);

  // Write side: interleaved address walk, bank completion and hand-over
  always_comb begin
    wr_sel_d  = wr_sel_q;
    wr_cnt_d  = wr_cnt_q;
    wr_addr_d = wr_addr_q;
    if (wr_acc) begin
      if (wr_cnt_q == LAST) begin
        wr_sel_d  = ~wr_sel_q;
        wr_cnt_d  = '0;
        wr_addr_d = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + ONE;
        if (wr_cnt_q[COL_W-1:0] == {COL_W{1'b1}})
          wr_addr_d = wr_addr_q - WRAP;
        else
          wr_addr_d = wr_addr_q + STEP;
      end
    end
  end

  // Read side: linear address walk, release of the drained bank, output valid
  always_comb begin
    rd_sel_d    = rd_sel_q;
    rd_cnt_d    = rd_cnt_q;
    rd_src_d    = rd_src_q;
    valid_out_d = valid_out_q;
    if (rd_issue) begin
      rd_src_d = rd_sel_q;
      if (rd_cnt_q == LAST) begin
        rd_sel_d = ~rd_sel_q;
        rd_cnt_d = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + ONE;
      end
    end
    if (~valid_out_q | ready_in)
      valid_out_d = rd_issue;
  end

  // Full flags: set on write completion, cleared on last read issue. The
  // writer only targets an empty bank and the reader a full one, so the two
  // updates never hit the same bit in one cycle.
  always_comb begin
    full_d = full_q;
    if (wr_acc && wr_cnt_q == LAST)
      full_d[wr_sel_q] = 1'b1;
    if (rd_issue && rd_cnt_q == LAST)
      full_d[rd_sel_q] = 1'b0;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_sel_q    <= 1'b0;
      wr_cnt_q    <= '0;
      wr_addr_q   <= '0;
      full_q      <= '0;
      rd_sel_q    <= 1'b0;
      rd_cnt_q    <= '0;
      valid_out_q <= 1'b0;
      rd_src_q    <= 1'b0;
    end else begin
      wr_sel_q    <= wr_sel_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_addr_q   <= wr_addr_d;
      full_q      <= full_d;
      rd_sel_q    <= rd_sel_d;
      rd_cnt_q    <= rd_cnt_d;
      valid_out_q <= valid_out_d;
      rd_src_q    <= rd_src_d;
    end
  end

  // Bank ports: idle bank addresses are parked at 0
  always_comb begin
    wren_A      = wr_acc & ~wr_sel_q;
    wren_B      = wr_acc &  wr_sel_q;
    wraddress_A = wren_A ? wr_addr_q : '0;
    wraddress_B = wren_B ? wr_addr_q : '0;
    wrdata_A    = data_in;
    wrdata_B    = data_in;
    rden_A      = rd_issue & ~rd_sel_q;
    rden_B      = rd_issue &  rd_sel_q;
    rdaddress_A = rden_A ? rd_cnt_q : '0;
    rdaddress_B = rden_B ? rd_cnt_q : '0;
  end

  assign valid_out = valid_out_q;
  // q holds while rden is low, so the mux alone keeps data_out stable
  assign data_out  = rd_src_q ? q_B : q_A;
  assign bank_full = full_q;

endmodule

// File: tb/tb_interleaver_pp_sched.sv
// Bench for interleaver_pp_sched: RAM bank models, a block-level model of the
// interleaver (input blocks in, permuted bits out), directed scenarios.
module tb_interleaver_pp_sched;

  logic       clk = 1'b0, resetN = 1'b0;
  logic       data_in = 1'b0, valid_in = 1'b0, ready_in = 1'b0;
  logic       ready_out, data_out, valid_out;
  logic       wren_A, wren_B, wrdata_A, wrdata_B, rden_A, rden_B;
  logic [7:0] wraddress_A, wraddress_B, rdaddress_A, rdaddress_B;
  logic       q_A = 1'b0, q_B = 1'b0;
  logic [1:0] bank_full;

  always #5 clk = ~clk;

  interleaver_pp_sched dut (
    .clk(clk), .resetN(resetN), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .wren_A(wren_A), .wren_B(wren_B),
    .wraddress_A(wraddress_A), .wraddress_B(wraddress_B),
    .wrdata_A(wrdata_A), .wrdata_B(wrdata_B), .rden_A(rden_A), .rden_B(rden_B),
    .rdaddress_A(rdaddress_A), .rdaddress_B(rdaddress_B),
    .q_A(q_A), .q_B(q_B), .bank_full(bank_full)
  );

  // Bank RAMs: 1-cycle read latency, q holds while rden is low
  logic ram_a [0:255];
  logic ram_b [0:255];
  always @(posedge clk) begin
    if (wren_A) ram_a[wraddress_A] <= wrdata_A;
    if (wren_B) ram_b[wraddress_B] <= wrdata_B;
    if (rden_A) q_A <= ram_a[rdaddress_A];
    if (rden_B) q_B <= ram_b[rdaddress_B];
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Interleaver rules in plain arithmetic
  function automatic int mk(input int k);
    return 12 * (k % 16) + k / 16;
  endfunction
  function automatic int src_k(input int n);
    return 16 * (n % 12) + n / 12;
  endfunction

  // Model state: partial input block, queue of completed blocks awaiting output
  logic [191:0] cur;
  logic [191:0] blkq[$];
  int k = 0, blocks_in = 0, blocks_out = 0, on_n = 0, cyc = 0;
  int rel;
  logic [1:0] fexp;
  bit b;
  logic [18:0] wa, we;
  bit prev_stall = 0;
  logic prev_d = 0;
  bit stat_clr = 0;
  int out_cnt = 0, first_v = -1, last_v = -1, rdy_low = 0, ones_cnt = 0, one_pos = -1;

  // Compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (stat_clr) begin
      out_cnt = 0; first_v = -1; last_v = -1; rdy_low = 0; ones_cnt = 0; one_pos = -1;
    end
    if (!resetN) begin
      cur = '0; k = 0; blkq.delete(); blocks_in = 0; blocks_out = 0; on_n = 0;
      prev_stall = 0;
    end else begin
      // A block is released once its last bit is on data_out
      rel = blocks_out + ((valid_out && on_n == 191) ? 1 : 0);
      fexp = 2'b00;
      for (int i = rel; i < blocks_in; i++) fexp[i % 2] = 1'b1;
      check("bank_full", int'(bank_full), int'(fexp));
      check("ready_out", int'(ready_out), int'((blocks_in - rel) < 2));
      if (!ready_out) rdy_low++;
      // output side
      if (prev_stall) check("stall_hold", int'({valid_out, data_out}), int'({1'b1, prev_d}));
      if (valid_out && !ready_in) check("stall_rden", int'({rden_A, rden_B}), 0);
      if (valid_out) begin
        check("out_avail", int'(blkq.size() > 0), 1);
        if (blkq.size() > 0 && ready_in) begin
          check("data_out", int'(data_out), int'(blkq[0][src_k(on_n)]));
          out_cnt++;
          if (first_v < 0) first_v = cyc;
          last_v = cyc;
          if (data_out) begin ones_cnt++; one_pos = on_n; end
          on_n++;
          if (on_n == 192) begin
            void'(blkq.pop_front());
            blocks_out++;
            on_n = 0;
          end
        end
      end
      prev_stall = valid_out && !ready_in;
      prev_d = data_out;
      // input side: blocks alternate A,B starting at A after reset
      if (valid_in && ready_out) begin
        b  = blocks_in[0];
        wa = {wren_B, wren_A, wraddress_B, wraddress_A, b ? wrdata_B : wrdata_A};
        we = {b ? 2'b10 : 2'b01, b ? 8'(mk(k)) : 8'd0, b ? 8'd0 : 8'(mk(k)), data_in};
        check("wr_port", int'(wa), int'(we));
        cur[k] = data_in;
        k++;
        if (k == 192) begin
          blkq.push_back(cur);
          blocks_in++;
          k = 0;
        end
      end else begin
        check("wr_idle", int'({wren_A, wren_B, wraddress_A, wraddress_B}), 0);
      end
    end
  end

  task automatic drive(input bit v, input bit d);
    @(posedge clk); #1;
    valid_in = v;
    data_in  = d;
  endtask

  task automatic clr_stats();
    @(posedge clk); #1 stat_clr = 1;
    @(negedge clk); #1 stat_clr = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((valid_out || bank_full != 2'b00) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_bound", int'(t < 1000), 1);
  endtask

  int idx_t[5] = '{0, 1, 15, 16, 191};
  int adr_t[5] = '{0, 12, 180, 1, 191};

  initial begin
    int t;
    // reset
    repeat (2) @(posedge clk);
    #1 resetN = 1;
    @(negedge clk);
    check("rst_ready_out", int'(ready_out), 1);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_bank_full", int'(bank_full), 0);
    check("rst_enables", int'({wren_A, wren_B, rden_A, rden_B}), 0);
    check("rst_addrs", int'({wraddress_A, wraddress_B, rdaddress_A, rdaddress_B}), 0);

    // address sequence into bank A
    ready_in = 1;
    for (int i = 0; i < 192; i++) begin
      drive(1, 1'($urandom_range(1)));
      @(negedge clk);
      for (int j = 0; j < 5; j++)
        if (i == idx_t[j]) check("addr_seq", int'(wraddress_A), adr_t[j]);
    end
    drive(0, 0);
    @(negedge clk);
    check("full_after_blk", int'(bank_full), 1);
    drain();

    // permutation: single 1 at k=17, latency to first output
    clr_stats();
    for (int i = 0; i < 192; i++) drive(1, i == 17);
    drive(0, 0);
    @(negedge clk);
    check("lat_t1", int'(valid_out), 0);
    @(negedge clk);
    check("lat_t2", int'({valid_out, data_out}), 2);
    drain();
    repeat (2) @(negedge clk);
    check("one_count", ones_cnt, 1);
    check("one_pos", one_pos, 13);

    // continuous streaming, 4 blocks
    clr_stats();
    for (int i = 0; i < 768; i++) drive(1, 1'($urandom_range(1)));
    drive(0, 0);
    drain();
    repeat (2) @(negedge clk);
    check("cont_outs", out_cnt, 768);
    check("cont_contig", last_v - first_v + 1, 768);
    check("cont_rdy_low", rdy_low, 0);

    // both banks full
    @(posedge clk); #1 ready_in = 0;
    for (int i = 0; i < 384; i++) drive(1, 1'($urandom_range(1)));
    drive(1, 1);
    @(negedge clk);
    check("both_full", int'({bank_full, ready_out}), 6);
    @(posedge clk); #1 valid_in = 0; ready_in = 1;
    @(posedge clk); #1 ready_in = 0;
    @(negedge clk);
    check("pulse_hold", int'(ready_out), 0);
    @(posedge clk); #1 ready_in = 1;
    t = 0;
    while (!ready_out && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("release_bound", int'(t < 400), 1);
    check("after_release_full", int'(bank_full), 2);
    drain();

    // output stall mid-block
    for (int i = 0; i < 192; i++) drive(1, 1'($urandom_range(1)));
    drive(0, 0);
    repeat (50) @(posedge clk);
    #1 ready_in = 0;
    repeat (5) @(posedge clk);
    #1 ready_in = 1;
    drain();
    repeat (2) @(negedge clk);
    check("stall_all_out", blkq.size() + on_n, 0);

    // reset mid-block
    for (int i = 0; i < 100; i++) drive(1, 1'($urandom_range(1)));
    @(posedge clk); #1 valid_in = 0; resetN = 0;
    @(posedge clk); #1 resetN = 1;
    @(negedge clk);
    check("rst_mid", int'({bank_full, valid_out, ready_out}), 1);
    drive(1, 1);
    @(negedge clk);
    check("restart_addr", int'({wren_A, wraddress_A}), 9'h100);
    for (int i = 1; i < 192; i++) drive(1, 1'($urandom_range(1)));
    drive(0, 0);
    drain();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1);
  end

endmodule

// File: doc/interleaver_pp_sched.md
# interleaver_pp_sched

Scheduler for the 192-bit ping-pong interleaver buffer, which has two RAM banks, A and B. On the write side it accepts one coded bit per handshake and writes it into the active bank at the 802.16 QPSK interleaved address. When that bank is full it hands the bank to the read side, which streams it out in linear address order with full valid/ready backpressure. It sits between the randomizer/FEC output and the modulator mapper, and owns every enable and address of both banks.

## Interface
- BLOCK_BITS, 192, bits per interleaver block (Ncbps).
- D, 16, interleaver column count; BLOCK_BITS/D (12) is the row stride.
- ADDR_W, 8, bank address width.

- clk  in  1  single clock, all logic on rising edge.
- resetN  in  1  synchronous, active-low reset, sampled on rising clk edge.
- data_in  in  1  coded input bit.
- valid_in  in  1  upstream bit valid.
- ready_out  out  1  block can accept a bit this cycle.
- data_out  out  1  interleaved output bit.
- valid_out  out  1  data_out valid.
- ready_in  in  1  downstream accepts data_out.
- wren_A / wren_B  out  1  bank write enable.
- wraddress_A / wraddress_B  out  ADDR_W  bank write address.
- wrdata_A / wrdata_B  out  1  bank write data (equal to data_in).
- rden_A / rden_B  out  1  bank read enable.
- rdaddress_A / rdaddress_B  out  ADDR_W  bank read address.
- q_A / q_B  in  1  bank read data, 1-cycle latency; holds its value while rden is low and is unaffected by writes.
- bank_full  out  2  [0]=A, [1]=B; bank holds a complete unread block.

## Operation
- State: wr_sel, wr_cnt k (0..191), wr_addr, full[1:0], rd_sel, rd_cnt (0..191), valid_out register, rd_src register.
- Write side:
  - ready_out = !full[wr_sel].
  - A write accept is valid_in && ready_out. On accept, assert the wren of the bank selected by wr_sel, with wraddress = mk and wrdata = data_in.
  - mk = 12*(k mod 16) + floor(k/16), with range 0..191.
  - Incremental form: mk(0)=0; if k[3:0]==15 then mk-=179, else mk+=12. The sequence runs 0,12,…,180,1,13,…,191.
  - On the accept with k==191: set full[wr_sel], toggle wr_sel, reset k and mk to 0.
- Read side:
  - A read issue is full[rd_sel] && (!valid_out || ready_in). On issue, assert the rden of bank rd_sel with rdaddress = rd_cnt, and set rd_src ← rd_sel.
  - On the issue with rd_cnt==191: clear full[rd_sel], toggle rd_sel, set rd_cnt ← 0. Otherwise rd_cnt increments.
  - valid_out ← issue when (!valid_out || ready_in); otherwise valid_out holds.
  - data_out = rd_src ? q_B : q_A.
- Boundary and corner cases:
  - All enables not listed above are 0. Addresses of an idle bank are don't-care and are driven 0.
  - Both banks full: ready_out=0 until the read side releases one.
  - Write completion (set full[x]) and read release (clear full[y], y≠x) in the same cycle update independently. The same bank is never set and cleared in one cycle.
  - A released bank may be rewritten the cycle after release while its last bit is still held in q/data_out. The write does not disturb q.
  - Reset mid-block: the partial block is discarded; everything returns to reset values.
- Resulting order: output n corresponds to input k = 16*(n mod 12) + floor(n/12).

## Timing
- Reset values: ready_out=1 (the first cycle after reset). valid_out=0, data_out=q_A passthrough. bank_full=0. All wren/rden=0, all addresses=0. wr_sel=rd_sel=0 (bank A), counters=0.
- Throughput: 1 bit/cycle in and 1 bit/cycle out sustained; there are no bubbles at bank switches on either side.
- Latency: last input bit of a block accepted in cycle t. full set at the end of t. Read of address 0 issued in t+1. valid_out=1 with input bit k=0 in t+2.
- Backpressure: while valid_out && !ready_in, no read is issued and data_out/valid_out stay stable.
- Input: while ready_out=0, valid_in is ignored and no wren is asserted.

## Test plan
- Address sequence: stream 192 bits with ready_in=1 → wraddress_A sequence is 0,12,24,…,180,1,13,…,191 on consecutive cycles. bank_full=01 after bit 191. wr_sel then points to B.
- Permutation: input bit k = (k==17) only → valid_out rises 2 cycles after the last input. Exactly output n=13 is 1 (k=16*1+1); all other outputs are 0.
- Continuous streaming: 4 blocks back-to-back with valid_in=ready_in=1 → ready_out stays 1 throughout. Output is 768 contiguous valid bits. Banks alternate A,B,A,B on both sides.
- Both full: ready_in=0, feed 384 bits → bank_full=11 and ready_out=0 at the 385th cycle. Raising ready_in for one beat still keeps ready_out=0 until 192 reads complete. ready_out returns to 1 the cycle after bank A is released.
- Output stall: hold ready_in=0 for 5 cycles mid-block → data_out and valid_out stable, no rden asserted. Resuming with ready_in=1 shows no lost or duplicated bits.
- Reset mid-operation: drop resetN for 1 cycle after 100 input bits → next cycle shows bank_full=0, valid_out=0, ready_out=1. The next block starts at wraddress 0 in bank A.
